lcv_mul_acc_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit with valid/ready handshaking on both ports and an internal accumulator register. It supersedes the fixed 16x16/33-bit combinational and single-delay MAC blocks. It gives the datapath a throughput-1, fixed-latency MAC/MSUB/MUL engine with back-pressure and optional saturation. The stage split matches the two-register DSP48 mapping (input register, then product register), followed by an accumulate register.

---
 rtl/lcv_mul_acc_pkg.sv | 46 ++++
 rtl/lcv_mul_acc_pipe_dsp_stage.sv | 58 +++++
 rtl/lcv_mul_acc_pipe.sv | 104 ++++++++++
 tb/tb_lcv_mul_acc_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcv_mul_acc_pkg.sv
// rtl/lcv_mul_acc_pkg.sv - opcodes and overflow-checked add helper for lcv_mul_acc_pipe
// Clamping on overflow is compiled in by LCV_MUL_ACC_PIPE_SAT_EN.
package lcv_mul_acc_pkg;

   localparam logic [1:0] LCV_OP_MUL  = 2'd0;
   localparam logic [1:0] LCV_OP_MAC  = 2'd1;
   localparam logic [1:0] LCV_OP_MSUB = 2'd2;
   localparam logic [1:0] LCV_OP_LOAD = 2'd3;

   typedef enum logic [1:0] {
      MUL  = LCV_OP_MUL,
      MAC  = LCV_OP_MAC,
      MSUB = LCV_OP_MSUB,
      LOAD = LCV_OP_LOAD
   } lcv_mul_acc_op_t;

   // Operands travel sign-extended to this width so one helper serves any ACC_WIDTH below it.
   localparam int LCV_MAX_W = 128;
   typedef logic signed [LCV_MAX_W-1:0] lcv_wide_t;

   // Returns {ovf, result}; the w-bit result is the low w bits (wrapped or clamped).
   function automatic logic [LCV_MAX_W:0] lcv_sat_add(
      input lcv_wide_t x,
      input lcv_wide_t y,
      input logic      sub,
      input int        w
   );
      lcv_wide_t sum;
      lcv_wide_t max_v;
      lcv_wide_t min_v;
      logic      ovf;
      sum   = sub ? (x - y) : (x + y);
      max_v = (lcv_wide_t'(1) <<< (w - 1)) - lcv_wide_t'(1);
      min_v = ~max_v;
      ovf   = (sum > max_v) || (sum < min_v);
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
      if (sum > max_v) begin
         sum = max_v;
      end else if (sum < min_v) begin
         sum = min_v;
      end
`endif
      return {ovf, sum};
   endfunction

endpackage

// File: rtl/lcv_mul_acc_pipe_dsp_stage.sv
// rtl/lcv_mul_acc_pipe_dsp_stage.sv - input register (S1) and product register (S2) of the MAC pipe
// Both stages share one advance enable so they map onto a single DSP slice.
(* use_dsp = "yes" *)
module lcv_mul_acc_dsp_stage
   import lcv_mul_acc_pkg::*;
#(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int ACC_WIDTH = 40
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        valid,
   input  lcv_mul_acc_op_t             op,
   input  logic signed [A_WIDTH-1:0]   a,
   input  logic signed [B_WIDTH-1:0]   b,
   input  logic signed [ACC_WIDTH-1:0] c,
   output logic                        prod_valid,
   output lcv_mul_acc_op_t             prod_op,
   output logic signed [ACC_WIDTH-1:0] prod,
   output logic signed [ACC_WIDTH-1:0] addend
);

   logic                        in_valid;
   lcv_mul_acc_op_t             in_op;
   logic signed [A_WIDTH-1:0]   in_a;
   logic signed [B_WIDTH-1:0]   in_b;
   logic signed [ACC_WIDTH-1:0] in_c;
   logic signed [A_WIDTH+B_WIDTH-1:0] mult;

   assign mult = in_a * in_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_valid   <= 1'b0;
         in_op      <= MUL;
         in_a       <= '0;
         in_b       <= '0;
         in_c       <= '0;
         prod_valid <= 1'b0;
         prod_op    <= MUL;
         prod       <= '0;
         addend     <= '0;
      end else if (en) begin
         in_valid   <= valid;
         in_op      <= op;
         in_a       <= a;
         in_b       <= b;
         in_c       <= c;
         prod_valid <= in_valid;
         prod_op    <= in_op;
         prod       <= ACC_WIDTH'(mult);
         addend     <= in_c;
      end
   end

endmodule

// File: rtl/lcv_mul_acc_pipe.sv
// rtl/lcv_mul_acc_pipe.sv - pipelined signed MUL/MAC/MSUB/LOAD unit with valid/ready ports
// Saturation on overflow is compiled in with LCV_MUL_ACC_PIPE_SAT_EN; default wraps.
module lcv_mul_acc_pipe
   import lcv_mul_acc_pkg::*;
#(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int ACC_WIDTH = 40
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        inp_valid,
   output logic                        inp_ready,
   input  logic [1:0]                  inp_op,
   input  logic signed [A_WIDTH-1:0]   inp_a,
   input  logic signed [B_WIDTH-1:0]   inp_b,
   input  logic signed [ACC_WIDTH-1:0] inp_c,
   output logic                        outp_valid,
   input  logic                        outp_ready,
   output logic signed [ACC_WIDTH-1:0] outp_data,
   output logic                        outp_ovf
);

   if (ACC_WIDTH < A_WIDTH + B_WIDTH || ACC_WIDTH >= LCV_MAX_W) begin : g_bad_width
      $error("lcv_mul_acc_pipe: ACC_WIDTH must hold A_WIDTH+B_WIDTH and stay below LCV_MAX_W");
   end

   logic                        en;
   logic                        prod_valid;
   lcv_mul_acc_op_t             prod_op;
   logic signed [ACC_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0] addend;
   logic signed [ACC_WIDTH-1:0] acc;
   lcv_wide_t                   add_x;
   lcv_wide_t                   add_y;
   logic                        add_sub;
   logic [LCV_MAX_W:0]          sum_pair;
   logic signed [ACC_WIDTH-1:0] res;
   logic                        res_ovf;
   logic                        unused_sum_hi;

   // The whole pipe advances together; a held output freezes every stage.
   assign en        = !outp_valid || outp_ready;
   assign inp_ready = en;

   lcv_mul_acc_dsp_stage #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_dsp (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .valid      (inp_valid),
      .op         (lcv_mul_acc_op_t'(inp_op)),
      .a          (inp_a),
      .b          (inp_b),
      .c          (inp_c),
      .prod_valid (prod_valid),
      .prod_op    (prod_op),
      .prod       (prod),
      .addend     (addend)
   );

   always_comb begin
      add_x   = lcv_wide_t'(acc);
      add_y   = lcv_wide_t'(prod);
      add_sub = 1'b0;
      case (prod_op)
         MUL:     add_x   = lcv_wide_t'(addend);
         MSUB:    add_sub = 1'b1;
         default: ;
      endcase
      sum_pair = lcv_sat_add(add_x, add_y, add_sub, ACC_WIDTH);
      res      = sum_pair[ACC_WIDTH-1:0];
      res_ovf  = sum_pair[LCV_MAX_W];
      // LOAD bypasses the adder entirely and can never overflow.
      if (prod_op == LOAD) begin
         res     = addend;
         res_ovf = 1'b0;
      end
   end

   assign unused_sum_hi = ^sum_pair[LCV_MAX_W-1:ACC_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         outp_valid <= 1'b0;
         outp_data  <= '0;
         outp_ovf   <= 1'b0;
         acc        <= '0;
      end else if (en) begin
         outp_valid <= prod_valid;
         if (prod_valid) begin
            outp_data <= res;
            outp_ovf  <= res_ovf;
            if (prod_op != MUL) begin
               acc <= res;
            end
         end
      end
   end

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// tb/tb_lcv_mul_acc_pipe.sv - self-checking bench for lcv_mul_acc_pipe
// Honours LCV_MUL_ACC_PIPE_SAT_EN in its reference model.
module tb_lcv_mul_acc_pipe;
   import lcv_mul_acc_pkg::*;

   localparam int AW = 16;
   localparam int BW = 16;
   localparam int CW = 40;
   localparam longint MAXV = (longint'(1) <<< (CW - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (CW - 1));
   localparam longint SPAN = longint'(1) <<< CW;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 inp_valid;
   logic                 inp_ready;
   logic [1:0]           inp_op;
   logic signed [AW-1:0] inp_a;
   logic signed [BW-1:0] inp_b;
   logic signed [CW-1:0] inp_c;
   logic                 outp_valid;
   logic                 outp_ready;
   logic signed [CW-1:0] outp_data;
   logic                 outp_ovf;

   always #5 clk = ~clk;

   lcv_mul_acc_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .inp_valid  (inp_valid),
      .inp_ready  (inp_ready),
      .inp_op     (inp_op),
      .inp_a      (inp_a),
      .inp_b      (inp_b),
      .inp_c      (inp_c),
      .outp_valid (outp_valid),
      .outp_ready (outp_ready),
      .outp_data  (outp_data),
      .outp_ovf   (outp_ovf)
   );

   typedef struct {
      longint data;
      bit     ovf;
      int     cyc;
   } exp_t;

   int      checks = 0;
   int      errors = 0;
   exp_t    sb[$];
   longint  got_log[$];
   longint  m_acc = 0;
   int      cyc = 0;
   bit      lat_chk = 1'b0;
   bit      last_stall = 1'b0;
   longint  last_data = 0;
   int      stall_cnt = 0;

   task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Exact result reduced to CW bits: clamp or wrap modulo 2^CW.
   function automatic longint fit(input longint v, output bit ovf);
      longint m;
      ovf = (v > MAXV) || (v < MINV);
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
`else
      m = (v - MINV) % SPAN;
      if (m < 0) m += SPAN;
      return m + MINV;
`endif
   endfunction

   function automatic exp_t model(input logic [1:0] op, input logic signed [AW-1:0] a,
                                  input logic signed [BW-1:0] b, input logic signed [CW-1:0] c);
      exp_t   e;
      longint p;
      bit     o;
      p = longint'(a) * longint'(b);
      case (op)
         2'd0: e.data = fit(longint'(c) + p, o);
         2'd1: begin e.data = fit(m_acc + p, o); m_acc = e.data; end
         2'd2: begin e.data = fit(m_acc - p, o); m_acc = e.data; end
         default: begin e.data = longint'(c); o = 1'b0; m_acc = e.data; end
      endcase
      e.ovf = o;
      e.cyc = cyc;
      return e;
   endfunction

   task automatic cycle(input bit v, input logic [1:0] op, input logic signed [AW-1:0] a,
                        input logic signed [BW-1:0] b, input logic signed [CW-1:0] c,
                        input bit rdy, output bit fired);
      exp_t e;
      @(negedge clk);
      inp_valid  = v;
      inp_op     = op;
      inp_a      = a;
      inp_b      = b;
      inp_c      = c;
      outp_ready = rdy;
      #1;
      cyc++;
      check_eq("inp_ready", inp_ready, !outp_valid || outp_ready);
      if (last_stall) begin
         check_eq("stall_valid", outp_valid, 1);
         check_eq("stall_hold", outp_data, last_data);
      end
      last_stall = outp_valid && !outp_ready;
      last_data  = outp_data;
      if (last_stall) stall_cnt++;
      if (outp_valid && outp_ready) begin
         if (sb.size() == 0) begin
            check_eq("out_without_in", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            check_eq("data", outp_data, e.data);
            check_eq("ovf", outp_ovf, e.ovf);
            if (lat_chk) check_eq("latency", cyc - e.cyc, 3);
            got_log.push_back(outp_data);
         end
      end
      fired = v && inp_ready;
      if (fired) sb.push_back(model(op, a, b, c));
   endtask

   task automatic drain();
      bit f;
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         cycle(1'b0, 2'd0, '0, '0, '0, 1'b1, f);
         n++;
      end
      check_eq("drain_empty", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      inp_valid  = 1'b0;
      outp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      m_acc      = 0;
      last_stall = 1'b0;
   endtask

   initial begin : main
      bit     f;
      int     idx;
      int     issued;
      int     n;
      logic [1:0]           op;
      logic signed [CW-1:0] c;
      logic [1:0]           ops[9];

      rst        = 1'b1;
      inp_valid  = 1'b0;
      inp_op     = 2'd0;
      inp_a      = '0;
      inp_b      = '0;
      inp_c      = '0;
      outp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_outp_valid", outp_valid, 0);
      check_eq("rst_outp_data", outp_data, 0);
      check_eq("rst_outp_ovf", outp_ovf, 0);
      check_eq("rst_inp_ready", inp_ready, 1);

      // MUL latency and untouched accumulator
      lat_chk = 1'b1;
      got_log.delete();
      cycle(1'b1, MUL, 3, -4, 100, 1'b1, f);
      drain();
      cycle(1'b1, MAC, 0, 0, 0, 1'b1, f);
      drain();
      check_eq("mul_count", got_log.size(), 2);
      if (got_log.size() == 2) begin
         check_eq("mul_result", got_log[0], 88);
         check_eq("mul_acc_zero", got_log[1], 0);
      end

      // back-to-back accumulate chain
      got_log.delete();
      cycle(1'b1, LOAD, 0, 0, 10, 1'b1, f);
      cycle(1'b1, MAC, 2, 5, 0, 1'b1, f);
      cycle(1'b1, MAC, -3, 7, 0, 1'b1, f);
      cycle(1'b1, MSUB, 4, 4, 0, 1'b1, f);
      drain();
      check_eq("chain_count", got_log.size(), 4);
      if (got_log.size() == 4) begin
         check_eq("chain0", got_log[0], 10);
         check_eq("chain1", got_log[1], 20);
         check_eq("chain2", got_log[2], -1);
         check_eq("chain3", got_log[3], -17);
      end

      // back-pressure: 5 stalled cycles mid-stream
      lat_chk = 1'b0;
      got_log.delete();
      stall_cnt = 0;
      ops[0] = LOAD;
      for (int i = 1; i < 9; i++) ops[i] = MAC;
      idx = 0;
      n   = 0;
      while (idx < 9 && n < 100) begin
         cycle(1'b1, ops[idx], 1, 1, 0, !(n >= 4 && n < 9), f);
         if (f) idx++;
         n++;
      end
      drain();
      check_eq("bp_stall_cycles", stall_cnt, 5);
      check_eq("bp_count", got_log.size(), 9);
      if (got_log.size() == 9)
         for (int i = 0; i < 9; i++) check_eq("bp_seq", got_log[i], i);

      // overflow at both ends of the range
      lat_chk = 1'b1;
      got_log.delete();
      cycle(1'b1, LOAD, 0, 0, CW'(MAXV), 1'b1, f);
      cycle(1'b1, MAC, 1, 1, 0, 1'b1, f);
      cycle(1'b1, MAC, 0, 0, 0, 1'b1, f);
      cycle(1'b1, LOAD, 0, 0, CW'(MINV), 1'b1, f);
      cycle(1'b1, MSUB, 1, 1, 0, 1'b1, f);
      drain();
      check_eq("ovf_count", got_log.size(), 5);
      if (got_log.size() == 5) begin
`ifdef LCV_MUL_ACC_PIPE_SAT_EN
         check_eq("ovf_pos", got_log[1], MAXV);
         check_eq("ovf_hold", got_log[2], MAXV);
         check_eq("ovf_neg", got_log[4], MINV);
`else
         check_eq("ovf_pos", got_log[1], MINV);
         check_eq("ovf_hold", got_log[2], MINV);
         check_eq("ovf_neg", got_log[4], MAXV);
`endif
      end

      // reset with three operations in flight
      lat_chk = 1'b0;
      cycle(1'b1, MAC, 100, 100, 0, 1'b1, f);
      cycle(1'b1, MAC, 100, 100, 0, 1'b1, f);
      cycle(1'b1, MAC, 100, 100, 0, 1'b1, f);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, MUL, 0, 0, 0, 1'b1, f);
         check_eq("rst_flush_valid", outp_valid, 0);
      end
      got_log.delete();
      cycle(1'b1, MAC, 2, 3, 0, 1'b1, f);
      drain();
      check_eq("rst_fresh_count", got_log.size(), 1);
      if (got_log.size() == 1) check_eq("rst_fresh_mac", got_log[0], 6);

      // random regression against the model
      issued = 0;
      n      = 0;
      while (issued < 10000 && n < 60000) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: c = CW'(longint'($urandom_range(0, 2000)) - 1000);
            1: c = CW'({$urandom(), $urandom()});
            2: c = CW'(MAXV - longint'($urandom_range(0, 1 << 20)));
            default: c = CW'(MINV + longint'($urandom_range(0, 1 << 20)));
         endcase
         cycle($urandom_range(0, 3) != 0, op, AW'($urandom()), BW'($urandom()), c,
               $urandom_range(0, 3) != 0, f);
         if (f) issued++;
         n++;
      end
      check_eq("rand_issued", issued, 10000);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
